// File: rtl/usr_sw_led_conditioner.sv
// Board-I/O conditioning: synchronizes and debounces the dip-switches, stretches
// LED requests to a visible width and optionally drives the top LED as a heartbeat.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_STABLE  | synchronized pin agrees with sw_db, counter idle at 0
//   ST_PENDING | pin disagrees with sw_db, counting toward acceptance
module usr_sw_led_conditioner #(
    parameter int NSW            = 8,
    parameter int NLED           = 16,
    parameter int DEB_CYCLES     = 1000000,
    parameter int STRETCH_CYCLES = 5000000,
    parameter int HB_BIT         = 26
) (
    input  logic            sys0_clk,
    input  logic            sys0_rst,
    input  logic [NSW-1:0]  usr_sw_pin,
    output logic [NSW-1:0]  sw_db,
    output logic            sw_chg,
    input  logic [NLED-1:0] led_req,
    input  logic            hb_en,
    output logic [NLED-1:0] led_out
);

    localparam int CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SCW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam int HBW = HB_BIT + 1;

    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [SCW-1:0] STR_LOAD = SCW'(STRETCH_CYCLES - 1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

    logic [NSW-1:0]  sync1_q;
    logic [NSW-1:0]  sync2_q;
    deb_state_e      state_q [NSW];
    deb_state_e      state_d [NSW];
    logic [CW-1:0]   cnt_q [NSW];
    logic [CW-1:0]   cnt_d [NSW];
    logic [NSW-1:0]  sw_db_q;
    logic [NSW-1:0]  sw_db_d;
    logic            sw_tog_q;
    logic            sw_chg_q;
    logic [SCW-1:0]  scnt_q [NLED];
    logic [SCW-1:0]  scnt_d [NLED];
    logic [NLED-1:0] led_q;
    logic [NLED-1:0] led_d;
    logic [HBW-1:0]  hb_q;

    always_comb begin
        sw_db_d = sw_db_q;
        for (int i = 0; i < NSW; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                ST_STABLE: begin
                    if (sync2_q[i] != sw_db_q[i]) begin
                        state_d[i] = ST_PENDING;
                        cnt_d[i]   = CW'(1);
                    end
                end
                ST_PENDING: begin
                    if (sync2_q[i] == sw_db_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        sw_db_d[i] = sync2_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
            endcase
        end
    end

    // The heartbeat only masks the top LED; its stretcher keeps counting underneath.
    always_comb begin
        for (int j = 0; j < NLED; j++) begin
            if (led_req[j]) begin
                scnt_d[j] = STR_LOAD;
            end else if (scnt_q[j] != '0) begin
                scnt_d[j] = scnt_q[j] - SCW'(1);
            end else begin
                scnt_d[j] = scnt_q[j];
            end
            led_d[j] = led_req[j] || (scnt_q[j] != '0);
        end
        if (hb_en) begin
            led_d[NLED-1] = hb_q[HB_BIT];
        end
    end

    always_ff @(posedge sys0_clk or posedge sys0_rst) begin
        if (sys0_rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            sw_db_q  <= '0;
            sw_tog_q <= 1'b0;
            sw_chg_q <= 1'b0;
            led_q    <= '0;
            hb_q     <= '0;
            for (int i = 0; i < NSW; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
            for (int j = 0; j < NLED; j++) begin
                scnt_q[j] <= '0;
            end
        end else begin
            sync1_q  <= usr_sw_pin;
            sync2_q  <= sync1_q;
            sw_db_q  <= sw_db_d;
            sw_tog_q <= |(sw_db_d ^ sw_db_q);
            sw_chg_q <= sw_tog_q;
            led_q    <= led_d;
            hb_q     <= hb_q + HBW'(1);
            for (int i = 0; i < NSW; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            for (int j = 0; j < NLED; j++) begin
                scnt_q[j] <= scnt_d[j];
            end
        end
    end

    assign sw_db   = sw_db_q;
    assign sw_chg  = sw_chg_q;
    assign led_out = led_q;

endmodule
